// File: rtl/ysyx_23060221_uart_slave.sv
// AXI4 responder for the UART THR/LSR pair: single-beat writes to THR feed a TX FIFO
// that drains to a valid/ready character sink; reads return the line-status byte.
//
// state   | meaning
// W_IDLE  | awready high, waiting for a write address
// W_DATA  | accepting write beats (single beat pushes, bursts are swallowed)
// W_RESP  | bvalid high until bready
// R_IDLE  | arready high, waiting for a read address
// R_DATA  | rvalid high, one beat per rready until rlast
module ysyx_23060221_uart_slave #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'ha00003f8
) (
  input  logic        clk,
  input  logic        rst,
  output logic        awready,
  input  logic        awvalid,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awid,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  output logic        wready,
  input  logic        wvalid,
  input  logic [63:0] wdata,
  input  logic [7:0]  wstrb,
  input  logic        wlast,
  input  logic        bready,
  output logic        bvalid,
  output logic [1:0]  bresp,
  output logic [3:0]  bid,
  output logic        arready,
  input  logic        arvalid,
  input  logic [31:0] araddr,
  input  logic [3:0]  arid,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic        rready,
  output logic        rvalid,
  output logic [1:0]  rresp,
  output logic [63:0] rdata,
  output logic        rlast,
  output logic [3:0]  rid,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state;
  r_state_t r_state;

  logic [31:0] aw_addr;
  logic [3:0]  aw_id;
  logic [7:0]  aw_len;
  logic [3:0]  ar_id;
  logic [7:0]  ar_len;
  logic [7:0]  r_cnt;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count, count_next;
  logic          fifo_empty, fifo_full, push, pop;
  logic [7:0]    push_byte, lsr;

  logic unused_inputs;
  assign unused_inputs = ^{awsize, awburst, araddr, arsize, arburst};

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);
  assign tx_valid   = ~fifo_empty;
  assign tx_data    = fifo_empty ? 8'h00 : fifo_mem[head];
  assign pop        = tx_valid & tx_ready;
  assign push_byte  = wdata[{aw_addr[2:0], 3'b000} +: 8];
  assign push       = (w_state == W_DATA) && wvalid && wready && (aw_len == 8'd0)
                      && wstrb[aw_addr[2:0]] && (aw_addr == BASE_ADDR);
  assign lsr        = {1'b0, fifo_empty, ~fifo_full, 5'b0};

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      count <= count_next;
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[tail] <= push_byte;
  end

  // wready is registered from the post-update count, so a pop only opens it next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state <= W_IDLE;
      awready <= 1'b1;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= 2'b00;
      bid     <= 4'd0;
      aw_addr <= 32'd0;
      aw_id   <= 4'd0;
      aw_len  <= 8'd0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (awvalid && awready) begin
            aw_addr <= awaddr;
            aw_id   <= awid;
            aw_len  <= awlen;
            awready <= 1'b0;
            wready  <= (awlen != 8'd0) || (count_next != FULL_CNT);
            w_state <= W_DATA;
          end
        end
        W_DATA: begin
          if (wvalid && wready && ((aw_len == 8'd0) || wlast)) begin
            wready  <= 1'b0;
            bvalid  <= 1'b1;
            bresp   <= (aw_len != 8'd0) ? 2'b10 : 2'b00;
            bid     <= aw_id;
            w_state <= W_RESP;
          end else begin
            wready <= (aw_len != 8'd0) || (count_next != FULL_CNT);
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            bresp   <= 2'b00;
            awready <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      arready <= 1'b1;
      rvalid  <= 1'b0;
      rresp   <= 2'b00;
      rdata   <= 64'd0;
      rlast   <= 1'b0;
      rid     <= 4'd0;
      ar_id   <= 4'd0;
      ar_len  <= 8'd0;
      r_cnt   <= 8'd0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (arvalid && arready) begin
            ar_id   <= arid;
            ar_len  <= arlen;
            r_cnt   <= 8'd0;
            arready <= 1'b0;
            rvalid  <= 1'b1;
            rid     <= arid;
            rlast   <= (arlen == 8'd0);
            rresp   <= (arlen == 8'd0) ? 2'b00 : 2'b10;
            rdata   <= (arlen == 8'd0) ? {16'd0, lsr, 40'd0} : 64'd0;
            r_state <= R_DATA;
          end
        end
        R_DATA: begin
          if (rready) begin
            if (rlast) begin
              rvalid  <= 1'b0;
              rlast   <= 1'b0;
              rresp   <= 2'b00;
              rdata   <= 64'd0;
              arready <= 1'b1;
              r_state <= R_IDLE;
            end else begin
              r_cnt <= r_cnt + 8'd1;
              rlast <= ((r_cnt + 8'd1) == ar_len);
              rid   <= ar_id;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_23060221_uart_slave.sv
// Scoreboard bench for the UART AXI responder: expected TX bytes are queued at W
// handshakes and checked at the character sink; AXI responses are checked inline.
module tb_ysyx_23060221_uart_slave;
  localparam logic [31:0] BASE = 32'ha00003f8;

  logic        clk = 1'b0, rst = 1'b1;
  logic        awready, awvalid = 0;
  logic [31:0] awaddr = 0;
  logic [3:0]  awid = 0;
  logic [7:0]  awlen = 0;
  logic [2:0]  awsize = 0;
  logic [1:0]  awburst = 0;
  logic        wready, wvalid = 0, wlast = 0;
  logic [63:0] wdata = 0;
  logic [7:0]  wstrb = 0;
  logic        bready = 0, bvalid;
  logic [1:0]  bresp;
  logic [3:0]  bid;
  logic        arready, arvalid = 0;
  logic [31:0] araddr = 0;
  logic [3:0]  arid = 0;
  logic [7:0]  arlen = 0;
  logic [2:0]  arsize = 0;
  logic [1:0]  arburst = 0;
  logic        rready = 0, rvalid, rlast;
  logic [1:0]  rresp;
  logic [63:0] rdata;
  logic [3:0]  rid;
  logic        tx_valid, tx_ready = 0;
  logic [7:0]  tx_data;

  int total = 0, bad = 0;
  logic [7:0] sb[$];

  ysyx_23060221_uart_slave dut (
    .clk(clk), .rst(rst),
    .awready(awready), .awvalid(awvalid), .awaddr(awaddr), .awid(awid), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .wready(wready), .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bready(bready), .bvalid(bvalid), .bresp(bresp), .bid(bid),
    .arready(arready), .arvalid(arvalid), .araddr(araddr), .arid(arid), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rready(rready), .rvalid(rvalid), .rresp(rresp), .rdata(rdata), .rlast(rlast), .rid(rid),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // sink side: every accepted character must match the oldest expected byte
  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) begin
      if (sb.size() == 0) chk("tx_unexpected", 64'(sb.size()), 64'd1);
      else chk("tx_data", 64'(tx_data), 64'(sb.pop_front()));
    end
  end

  task automatic do_aw(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len);
    awvalid = 1; awaddr = a; awid = id; awlen = len;
    for (int k = 0; k < 50 && !awready; k++) step();
    chk("aw_ready", 64'(awready), 64'd1);
    step();
    awvalid = 0;
  endtask

  task automatic do_w(input logic [63:0] d, input logic [7:0] s, input logic last, input logic exp_push);
    wvalid = 1; wdata = d; wstrb = s; wlast = last;
    for (int k = 0; k < 50 && !wready; k++) step();
    chk("w_ready", 64'(wready), 64'd1);
    if (exp_push) sb.push_back(d[7:0]);
    step();
    wvalid = 0; wlast = 0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                    input logic [63:0] d, input logic [7:0] s);
    logic exp_push;
    exp_push = (len == 0) && (a == BASE) && s[a[2:0]];
    do_aw(a, id, len);
    chk("wready_lat", 64'(wready), 64'd1);
    for (int b = 0; b <= int'(len); b++) do_w(d + 64'(b), s, b == int'(len), exp_push);
    chk("bvalid_lat", 64'(bvalid), 64'd1);
    chk("bresp", 64'(bresp), (len != 0) ? 64'd2 : 64'd0);
    chk("bid", 64'(bid), 64'(id));
    if (exp_push) chk("tx_valid_next", 64'(tx_valid), 64'd1);
    bready = 1; step(); bready = 0;
    chk("b_done", 64'(bvalid), 64'd0);
  endtask

  task automatic rd(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len, input logic [7:0] exp_lsr);
    arvalid = 1; araddr = a; arid = id; arlen = len;
    for (int k = 0; k < 50 && !arready; k++) step();
    chk("ar_ready", 64'(arready), 64'd1);
    step();
    arvalid = 0;
    for (int b = 0; b <= int'(len); b++) begin
      chk("rvalid", 64'(rvalid), 64'd1);
      chk("rid", 64'(rid), 64'(id));
      chk("rresp", 64'(rresp), (len != 0) ? 64'd2 : 64'd0);
      chk("rdata", rdata, (len != 0) ? 64'd0 : {16'd0, exp_lsr, 40'd0});
      chk("rlast", 64'(rlast), (b == int'(len)) ? 64'd1 : 64'd0);
      rready = 1; step(); rready = 0;
    end
    chk("r_done", 64'(rvalid), 64'd0);
  endtask

  task automatic drain();
    tx_ready = 1;
    for (int k = 0; k < 100 && tx_valid; k++) step();
    chk("drain", 64'(tx_valid), 64'd0);
    chk("sb_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    #1;
    step(); step();
    chk("rst_ready", {awready, arready, wready}, 3'b110);
    chk("rst_b", {bvalid, bresp, bid}, 7'd0);
    chk("rst_r", {rvalid, rresp, rlast, rid}, 8'd0);
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_tx", {tx_valid, tx_data}, 9'd0);
    rst = 0;

    // single write, upper lanes carry junk to expose wrong byte selection
    wr(BASE, 4'd3, 8'd0, 64'hdeadbeef_cafe_0041, 8'h01);
    chk("tx_head", 64'(tx_data), 64'h41);
    rd(BASE + 5, 4'd1, 8'd0, 8'h20);
    drain();

    rd(32'ha00003fd, 4'd5, 8'd0, 8'h60);
    wr(BASE + 1, 4'd2, 8'd0, 64'h4200, 8'h02);
    wr(BASE, 4'd4, 8'd0, 64'h43, 8'h02);
    wr(32'ha0000400, 4'd6, 8'd0, 64'h44, 8'hff);

    // fill the FIFO, then a ninth write must stall until the sink drains
    tx_ready = 0;
    for (int i = 0; i < 8; i++) wr(BASE, 4'(i), 8'd0, 64'h30 + 64'(i), 8'h01);
    rd(BASE + 5, 4'd7, 8'd0, 8'h00);
    do_aw(BASE, 4'd9, 8'd0);
    wvalid = 1; wdata = 64'h38; wstrb = 8'h01; wlast = 1;
    for (int k = 0; k < 5; k++) begin
      chk("full_wready", 64'(wready), 64'd0);
      step();
    end
    tx_ready = 1;
    chk("pop_no_open", 64'(wready), 64'd0);
    do_w(64'h38, 8'h01, 1'b1, 1'b1);
    chk("full_bvalid", 64'(bvalid), 64'd1);
    bready = 1; step(); bready = 0;
    drain();

    // illegal bursts
    wr(BASE, 4'd10, 8'd3, 64'h50, 8'h01);
    rd(BASE + 5, 4'd11, 8'd1, 8'h00);

    // concurrent write and read with response backpressure
    awvalid = 1; awaddr = BASE; awid = 4'd12; awlen = 0;
    arvalid = 1; araddr = BASE + 5; arid = 4'd13; arlen = 0;
    step();
    awvalid = 0; arvalid = 0;
    do_w(64'h55, 8'h01, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      chk("hold_b", {bvalid, bresp, bid}, {1'b1, 2'b00, 4'd12});
      chk("hold_r", {rvalid, rresp, rlast, rid}, {1'b1, 2'b00, 1'b1, 4'd13});
      chk("hold_rdata", rdata, 64'h0000_6000_0000_0000);
      step();
    end
    bready = 1; rready = 1; step(); bready = 0; rready = 0;
    chk("conc_done", {bvalid, rvalid}, 2'b00);
    drain();

    // reset while both responses are pending and the FIFO holds a byte
    tx_ready = 0;
    do_aw(BASE, 4'd14, 8'd0);
    do_w(64'h66, 8'h01, 1'b1, 1'b1);
    arvalid = 1; araddr = BASE + 5; arid = 4'd15; arlen = 0;
    step();
    arvalid = 0;
    chk("pre_rst", {bvalid, rvalid, tx_valid}, 3'b111);
    rst = 1; sb.delete();
    step();
    rst = 0;
    chk("mid_rst", {bvalid, rvalid, tx_valid}, 3'b000);
    chk("mid_rst_rdy", {awready, arready}, 2'b11);

    wr(BASE, 4'd1, 8'd0, 64'h77, 8'h01);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
